// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate stage: default widths and FSM encoding.
package mac_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ACC_W_DEF   = 20;
  localparam int COUNT_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_accum_ctrl_if.sv
// Control, operand and result signals between the MAC controller (master) and the
// accumulate stage (slave).
interface mac_accum_ctrl_if
  import mac_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
);

  logic               start;
  logic [COUNT_W-1:0] n_terms;
  logic               in_valid;
  logic [DATA_W-1:0]  a_in;
  logic [DATA_W-1:0]  b_in;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [ACC_W-1:0]   acc_out;
  logic               ovf;

  modport master (
    output start, n_terms, in_valid, a_in, b_in,
    input  in_ready, busy, done, acc_out, ovf
  );

  modport slave (
    input  start, n_terms, in_valid, a_in, b_in,
    output in_ready, busy, done, acc_out, ovf
  );

endinterface

// File: rtl/mac_product_stage.sv
// One-deep unsigned product pipeline: registers a_in*b_in on each accepted handshake
// and flags it valid for exactly the following edge unless another pair arrives.
module mac_product_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_ready,
  input  logic [DATA_W-1:0]   a_in,
  input  logic [DATA_W-1:0]   b_in,
  output logic                hs,
  output logic [2*DATA_W-1:0] prod_q,
  output logic                prod_v
);

  logic [2*DATA_W-1:0] prod_next;

  assign hs        = in_valid & in_ready;
  assign prod_next = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      prod_v <= 1'b0;
    end else begin
      prod_v <= hs;
      if (hs) begin
        prod_q <= prod_next;
      end
    end
  end

endmodule

// File: rtl/mac_accum_ctrl.sv
// Sequencing multiply-accumulate stage: runs n_terms operand handshakes through the
// product stage, sums the products into a wide accumulator and pulses done.
module mac_accum_ctrl
  import mac_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input logic             clk,
  input logic             reset,
  mac_accum_ctrl_if.slave bus
);

  state_e               state_reg, state_next;
  logic [COUNT_W-1:0]   cnt_reg, cnt_next;
  logic [ACC_W-1:0]     acc_reg, acc_next;
  logic                 ovf_reg, ovf_next;
  logic                 hs;
  logic                 prod_v;
  logic [2*DATA_W-1:0]  prod_q;
  logic [ACC_W:0]       acc_sum;

  mac_product_stage #(.DATA_W(DATA_W)) u_prod (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .a_in     (bus.a_in),
    .b_in     (bus.b_in),
    .hs       (hs),
    .prod_q   (prod_q),
    .prod_v   (prod_v)
  );

  // Extra top bit of the sum is the carry that feeds the sticky overflow flag.
  assign acc_sum = {1'b0, acc_reg} + (ACC_W+1)'(prod_q);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;

    if (prod_v) begin
      acc_next = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        ovf_next = 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = bus.n_terms;
          state_next = (bus.n_terms != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (hs) begin
          cnt_next = cnt_reg - COUNT_W'(1);
          if (cnt_reg == COUNT_W'(1)) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign bus.in_ready = (state_reg == ST_ACCUM);
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.acc_out  = acc_reg;
  assign bus.ovf      = ovf_reg;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Directed bench for mac_accum_ctrl: a sum model pushes expected results at start,
// popped and compared when done pulses.
module tb_mac_accum_ctrl;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_accum_ctrl_if bus ();

  mac_accum_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [19:0] acc;
    logic        ovf;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  exp_t        sb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  // Model the run over the first n queued pairs, then pulse start for one cycle.
  task automatic start_run(input int n, input logic [4:0] nt);
    exp_t   e;
    longint s;
    s     = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s += longint'(qa[i]) * longint'(qb[i]);
      if (s >= (longint'(1) << 20)) begin
        e.ovf = 1'b1;
        s -= (longint'(1) << 20);
      end
    end
    e.acc = s[19:0];
    sb.push_back(e);
    bus.start   = 1'b1;
    bus.n_terms = nt;
    tick;
    bus.start = 1'b0;
    if (n != 0) begin
      chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
      chk("ready_after_start", {31'd0, bus.in_ready}, 32'd1);
    end
  endtask

  // Offer pairs with in_valid following vpat; optionally pulse start at cycle start_at.
  task automatic feed(input int n, input logic [7:0] vpat, input int plen, input int start_at);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      bus.in_valid = vpat[cyc % plen];
      bus.a_in     = qa[0];
      bus.b_in     = qb[0];
      bus.start    = (cyc == start_at);
      bus.n_terms  = 5'd2;
      if (bus.in_valid && bus.in_ready) begin
        got++;
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      tick;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (got < n) begin
      chk("feed_timeout", got, n);
    end
  endtask

  task automatic check_drain(input string tag);
    chk({tag, "_drain_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_drain_busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_drain_done"}, {31'd0, bus.done}, 32'd0);
    tick;
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_acc"}, {12'd0, bus.acc_out}, {12'd0, e.acc});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, e.ovf});
    $display("run %s: acc_out=%0d ovf=%0d expected acc=%0d ovf=%0d",
             tag, bus.acc_out, bus.ovf, e.acc, e.ovf);
    tick;
    chk({tag, "_busy_fall"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_acc_hold"}, {12'd0, bus.acc_out}, {12'd0, e.acc});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_acc"}, {12'd0, bus.acc_out}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, 32'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.n_terms  = 5'd0;
    bus.in_valid = 1'b0;
    bus.a_in     = 8'd0;
    bus.b_in     = 8'd0;
    reset        = 1'b1;
    tick;
    tick;
    check_reset_vals("por");
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    tick;
    chk("idle_no_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;

    // Basic run, continuous in_valid
    push_pair(8'd3, 8'd4); push_pair(8'd5, 8'd6); push_pair(8'd255, 8'd255);
    start_run(3, 5'd3);
    feed(3, 8'b1, 1, -1);
    check_drain("basic");
    check_done("basic");
    chk("basic_const", {12'd0, bus.acc_out}, 32'd65067);

    // Same run with in_valid toggling 1,0,0,1,0,1
    push_pair(8'd3, 8'd4); push_pair(8'd5, 8'd6); push_pair(8'd255, 8'd255);
    start_run(3, 5'd3);
    feed(3, 8'b0010_1001, 6, -1);
    check_drain("bubble");
    check_done("bubble");

    // Overflow: 17 x (255*255) wraps the 20-bit accumulator
    for (int i = 0; i < 17; i++) push_pair(8'd255, 8'd255);
    start_run(17, 5'd17);
    feed(17, 8'b1, 1, -1);
    check_drain("ovf");
    check_done("ovf");
    tick; tick; tick;
    chk("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    chk("ovf_acc_hold", {12'd0, bus.acc_out}, 32'd56849);

    // Zero terms: done in the cycle right after start, ovf cleared
    start_run(0, 5'd0);
    check_done("zero");

    // start pulsed while busy must be ignored
    push_pair(8'd10, 8'd20); push_pair(8'd30, 8'd40);
    push_pair(8'd1, 8'd2);   push_pair(8'd200, 8'd100);
    start_run(4, 5'd4);
    feed(4, 8'b1011, 4, 1);
    check_drain("busystart");
    check_done("busystart");

    // Reset after 2 of 5 handshakes, held 2 cycles with in_valid high
    push_pair(8'd3, 8'd4); push_pair(8'd5, 8'd6);
    push_pair(8'd1, 8'd1); push_pair(8'd1, 8'd1); push_pair(8'd1, 8'd1);
    start_run(5, 5'd5);
    feed(2, 8'b1, 1, -1);
    void'(sb.pop_back());
    qa.delete();
    qb.delete();
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    tick;
    check_reset_vals("midrst1");
    tick;
    check_reset_vals("midrst2");
    reset = 1'b0;
    tick;
    check_reset_vals("postrst");
    bus.in_valid = 1'b0;
    tick;
    chk("postrst_no_done", {31'd0, bus.done}, 32'd0);

    // Single-term run after the reset
    push_pair(8'd7, 8'd9);
    start_run(1, 5'd1);
    feed(1, 8'b1, 1, -1);
    check_drain("one");
    check_done("one");
    chk("one_const", {12'd0, bus.acc_out}, 32'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
